// File: rtl/banco_registrador_mp.sv
// ---------------------------------------------------------------------------
// banco_registrador_mp
//
// Multi-port register file for the fewcore datapath. Provides NREAD
// registered read ports and two write ports. Write port 1 wins over
// write port 0. Register 0 can be hardwired to zero. Same-cycle write
// data can optionally be forwarded to reads.
//
// After reset a sequential clear engine zeroes every register, one per
// cycle. While it runs, busy is high, writes are ignored and reads return 0.
//
// Ports
//   clk        in   clock; all logic on posedge
//   reset      in   synchronous reset, active-low
//   rs         in   NREAD read addresses, port i at [i*ADDRESSLEN +: ADDRESSLEN]
//   r          out  NREAD registered read data, port i at [i*XLEN +: XLEN]
//   wEn0       in   write enable, port 0
//   rd0        in   write address, port 0
//   data0      in   write data, port 0
//   wEn1       in   write enable, port 1 (priority over port 0)
//   rd1        in   write address, port 1
//   data1      in   write data, port 1
//   busy       out  clear engine running; the core must stall
//   wconflict  out  1-cycle pulse: both ports wrote the same effective address
// ---------------------------------------------------------------------------
module banco_registrador_mp #(
    parameter int XLEN       = 32,
    parameter int AMOUNT     = 16,
    parameter int ADDRESSLEN = 4,
    parameter int NREAD      = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREAD*ADDRESSLEN-1:0]   rs,
    output logic [NREAD*XLEN-1:0]         r,
    input  logic                          wEn0,
    input  logic [ADDRESSLEN-1:0]         rd0,
    input  logic [XLEN-1:0]               data0,
    input  logic                          wEn1,
    input  logic [ADDRESSLEN-1:0]         rd1,
    input  logic [XLEN-1:0]               data1,
    output logic                          busy,
    output logic                          wconflict
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // One extra bit so that AMOUNT == 2**ADDRESSLEN is representable.
    localparam logic [ADDRESSLEN:0]   AMOUNT_W = (ADDRESSLEN+1)'(AMOUNT);
    localparam logic [ADDRESSLEN-1:0] LAST_PTR = ADDRESSLEN'(AMOUNT - 1);

    state_t                  state_q, state_d;
    logic [ADDRESSLEN-1:0]   clr_ptr_q, clr_ptr_d;
    logic                    busy_q, busy_d;
    logic                    wconf_q, wconf_d;
    logic [XLEN-1:0]         regs_q [AMOUNT];
    logic [XLEN-1:0]         r_q    [NREAD];
    logic [XLEN-1:0]         r_d    [NREAD];

    logic                    run;
    logic                    we0_eff;
    logic                    we1_eff;

    function automatic logic addr_ok(input logic [ADDRESSLEN-1:0] a);
        return {1'b0, a} < AMOUNT_W;
    endfunction

    function automatic logic is_zero_reg(input logic [ADDRESSLEN-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign run     = (state_q == ST_RUN);
    assign we0_eff = run && wEn0 && addr_ok(rd0) && !is_zero_reg(rd0);
    assign we1_eff = run && wEn1 && addr_ok(rd1) && !is_zero_reg(rd1);

    // Clear engine: walk clr_ptr over every register, then hand over to RUN.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        busy_d    = busy_q;
        case (state_q)
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Conflict only counts writes that would actually land, so two writes
    // to a hardwired-zero or out-of-range address do not pulse.
    assign wconf_d = we0_eff && we1_eff && (rd0 == rd1);

    // Read selection, one independent mux per port.
    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [ADDRESSLEN-1:0] addr;
        logic [XLEN-1:0]       sel;

        assign addr = rs[g*ADDRESSLEN +: ADDRESSLEN];

        always_comb begin
            sel = '0;
            if (is_zero_reg(addr)) begin
                sel = '0;
            end else if (!addr_ok(addr)) begin
                sel = '0;
            end else if ((BYPASS != 0) && we1_eff && (rd1 == addr)) begin
                sel = data1;
            end else if ((BYPASS != 0) && we0_eff && (rd0 == addr)) begin
                sel = data0;
            end else begin
                sel = regs_q[addr];
            end
        end

        assign r_d[g] = run ? sel : '0;
        assign r[g*XLEN +: XLEN] = r_q[g];
    end

    // Stage boundary: control state and registered read outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
            wconf_q   <= 1'b0;
            for (int i = 0; i < NREAD; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
            wconf_q   <= wconf_d;
            for (int i = 0; i < NREAD; i++) begin
                r_q[i] <= r_d[i];
            end
        end
    end

    // Stage boundary: storage array. Port 1 is written last so it wins
    // when both ports hit the same address.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state_q == ST_CLEAR) begin
                regs_q[clr_ptr_q] <= '0;
            end else begin
                if (we0_eff) begin
                    regs_q[rd0] <= data0;
                end
                if (we1_eff) begin
                    regs_q[rd1] <= data1;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign wconflict = wconf_q;

endmodule

// File: tb/tb_banco_registrador_mp.sv
module tb_banco_registrador_mp;

    logic        clk;
    logic        reset;
    logic [7:0]  rs;
    logic        wEn0, wEn1;
    logic [3:0]  rd0, rd1;
    logic [31:0] data0, data1;

    logic [63:0] r_a, r_b, r_c;
    logic        busy_a, busy_b, busy_c;
    logic        wconf_a, wconf_b, wconf_c;

    int total = 0;
    int bad   = 0;

    // Default configuration.
    banco_registrador_mp #(.XLEN(32), .AMOUNT(16), .ADDRESSLEN(4), .NREAD(2),
                           .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .rs(rs), .r(r_a),
        .wEn0(wEn0), .rd0(rd0), .data0(data0),
        .wEn1(wEn1), .rd1(rd1), .data1(data1),
        .busy(busy_a), .wconflict(wconf_a)
    );

    // No bypass.
    banco_registrador_mp #(.XLEN(32), .AMOUNT(16), .ADDRESSLEN(4), .NREAD(2),
                           .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rs(rs), .r(r_b),
        .wEn0(wEn0), .rd0(rd0), .data0(data0),
        .wEn1(wEn1), .rd1(rd1), .data1(data1),
        .busy(busy_b), .wconflict(wconf_b)
    );

    // Twelve registers behind a 4-bit address.
    banco_registrador_mp #(.XLEN(32), .AMOUNT(12), .ADDRESSLEN(4), .NREAD(2),
                           .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset), .rs(rs), .r(r_c),
        .wEn0(wEn0), .rd0(rd0), .data0(data0),
        .wEn1(wEn1), .rd1(rd1), .data1(data1),
        .busy(busy_c), .wconflict(wconf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        wEn0 = 1'b0; wEn1 = 1'b0;
        rd0 = 4'd0; rd1 = 4'd0;
        data0 = 32'h0; data1 = 32'h0;
    endtask

    task automatic test_reset;
        int n_a, n_c;
        logic conf_seen;
        reset = 1'b0; rs = 8'h00;
        idle_inputs();
        tick(); tick();
        total++;
        if (busy_a !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b expected 1", busy_a); end
        total++;
        if (r_a !== 64'h0) begin bad++; $display("FAIL reset_r: got %h expected 0", r_a); end
        total++;
        if (wconf_a !== 1'b0) begin bad++; $display("FAIL reset_wconflict: got %b expected 0", wconf_a); end

        // Release reset with conflicting writes pending; they must be ignored.
        reset = 1'b1;
        wEn0 = 1'b1; rd0 = 4'd5; data0 = 32'hAAAA5555;
        wEn1 = 1'b1; rd1 = 4'd5; data1 = 32'h5555AAAA;
        n_a = 0; n_c = 0; conf_seen = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (wconf_a !== 1'b0) conf_seen = 1'b1;
            if (n_c == 0 && busy_c === 1'b0) n_c = n;
            if (busy_a === 1'b0) begin n_a = n; break; end
        end
        idle_inputs();
        total++;
        if (n_a != 16) begin bad++; $display("FAIL clear_len16: got %0d expected 16", n_a); end
        total++;
        if (n_c != 12) begin bad++; $display("FAIL clear_len12: got %0d expected 12", n_c); end
        total++;
        if (conf_seen !== 1'b0) begin bad++; $display("FAIL clear_wconflict: got %b expected 0", conf_seen); end

        for (int a = 0; a < 16; a++) begin
            rs = {2{4'(a)}};
            tick();
            total++;
            if (r_a !== 64'h0) begin bad++; $display("FAIL clear_read a=%0d: got %h expected 0", a, r_a); end
        end
    endtask

    task automatic test_basic;
        wEn0 = 1'b1; rd0 = 4'd5; data0 = 32'hDEADBEEF; rs = 8'h11;
        tick();
        idle_inputs();
        rs = 8'h55;
        tick();
        total++;
        if (r_a !== 64'hDEADBEEF_DEADBEEF) begin bad++; $display("FAIL basic_a: got %h expected deadbeefdeadbeef", r_a); end
        total++;
        if (r_b !== 64'hDEADBEEF_DEADBEEF) begin bad++; $display("FAIL basic_b: got %h expected deadbeefdeadbeef", r_b); end
    endtask

    task automatic test_bypass;
        wEn0 = 1'b1; rd0 = 4'd7; data0 = 32'h12345678; rs = 8'h77;
        tick();
        total++;
        if (r_a !== 64'h12345678_12345678) begin bad++; $display("FAIL bypass_on: got %h expected 1234567812345678", r_a); end
        total++;
        if (r_b !== 64'h0) begin bad++; $display("FAIL bypass_off_old: got %h expected 0", r_b); end
        idle_inputs();
        tick();
        total++;
        if (r_b !== 64'h12345678_12345678) begin bad++; $display("FAIL bypass_off_new: got %h expected 1234567812345678", r_b); end
    endtask

    task automatic test_conflict;
        wEn0 = 1'b1; rd0 = 4'd3; data0 = 32'h00001111;
        wEn1 = 1'b1; rd1 = 4'd3; data1 = 32'h00002222;
        rs = 8'h33;
        tick();
        total++;
        if (wconf_a !== 1'b1) begin bad++; $display("FAIL conflict_pulse: got %b expected 1", wconf_a); end
        total++;
        if (r_a !== 64'h00002222_00002222) begin bad++; $display("FAIL conflict_bypass: got %h expected 0000222200002222", r_a); end
        idle_inputs();
        tick();
        total++;
        if (wconf_a !== 1'b0) begin bad++; $display("FAIL conflict_one_cycle: got %b expected 0", wconf_a); end
        total++;
        if (r_b !== 64'h00002222_00002222) begin bad++; $display("FAIL conflict_stored: got %h expected 0000222200002222", r_b); end

        wEn0 = 1'b1; rd0 = 4'd0; data0 = 32'h00001111;
        wEn1 = 1'b1; rd1 = 4'd0; data1 = 32'h00002222;
        rs = 8'h00;
        tick();
        idle_inputs();
        total++;
        if (wconf_a !== 1'b0) begin bad++; $display("FAIL conflict_r0_pulse: got %b expected 0", wconf_a); end
        total++;
        if (r_a !== 64'h0) begin bad++; $display("FAIL conflict_r0_read: got %h expected 0", r_a); end
    endtask

    task automatic test_zero_and_range;
        wEn0 = 1'b1; rd0 = 4'd0; data0 = 32'hFFFFFFFF; rs = 8'h00;
        tick();
        idle_inputs();
        total++;
        if (r_a !== 64'h0) begin bad++; $display("FAIL zero_same_cycle: got %h expected 0", r_a); end
        tick();
        total++;
        if (r_a !== 64'h0) begin bad++; $display("FAIL zero_after: got %h expected 0", r_a); end

        // Port 0 reads r11 (last valid), port 1 reads r13 (out of range).
        wEn0 = 1'b1; rd0 = 4'd13; data0 = 32'hCAFE0000;
        wEn1 = 1'b1; rd1 = 4'd11; data1 = 32'h0B0B0B0B;
        rs = {4'd13, 4'd11};
        tick();
        idle_inputs();
        total++;
        if (r_c !== 64'h00000000_0B0B0B0B) begin bad++; $display("FAIL range_same_cycle: got %h expected 000000000b0b0b0b", r_c); end
        total++;
        if (wconf_c !== 1'b0) begin bad++; $display("FAIL range_wconflict: got %b expected 0", wconf_c); end
        tick();
        total++;
        if (r_c !== 64'h00000000_0B0B0B0B) begin bad++; $display("FAIL range_after: got %h expected 000000000b0b0b0b", r_c); end
    endtask

    task automatic test_back_to_back;
        wEn0 = 1'b1; rd0 = 4'd8; data0 = 32'h88888888;
        wEn1 = 1'b1; rd1 = 4'd9; data1 = 32'h99999999;
        tick();
        total++;
        if (wconf_a !== 1'b0) begin bad++; $display("FAIL dual_wconflict: got %b expected 0", wconf_a); end
        // Next writes overlap the read of the previous ones.
        wEn0 = 1'b1; rd0 = 4'd10; data0 = 32'hA0A0A0A0;
        wEn1 = 1'b0;
        rs = {4'd9, 4'd8};
        tick();
        idle_inputs();
        total++;
        if (r_b !== 64'h99999999_88888888) begin bad++; $display("FAIL dual_read: got %h expected 9999999988888888", r_b); end
        rs = {4'd10, 4'd5};
        tick();
        total++;
        if (r_b !== 64'hA0A0A0A0_DEADBEEF) begin bad++; $display("FAIL b2b_read: got %h expected a0a0a0a0deadbeef", r_b); end
    endtask

    task automatic test_reset_mid_clear;
        int n_a;
        logic held;
        reset = 1'b0;
        idle_inputs();
        tick();
        reset = 1'b1;
        held = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (busy_a !== 1'b1) held = 1'b0;
        end
        reset = 1'b0;
        tick();
        total++;
        if (held !== 1'b1 || busy_a !== 1'b1) begin bad++; $display("FAIL midclear_busy: got %b/%b expected 1/1", held, busy_a); end
        reset = 1'b1;
        n_a = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (busy_a === 1'b0) begin n_a = n; break; end
        end
        total++;
        if (n_a != 16) begin bad++; $display("FAIL midclear_len: got %0d expected 16", n_a); end
        for (int a = 0; a < 16; a++) begin
            rs = {2{4'(a)}};
            tick();
            total++;
            if (r_a !== 64'h0 || r_b !== 64'h0) begin
                bad++;
                $display("FAIL midclear_read a=%0d: got %h/%h expected 0/0", a, r_a, r_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_conflict();
        test_zero_and_range();
        test_back_to_back();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/banco_registrador_mp.md
Name: banco_registrador_mp

Overview:
- Parametrised multi-port register file; successor to the core's 2-read/1-write bank.
- Provides NREAD registered read ports and two write ports with fixed priority.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Includes a sequential clear engine that zeroes every register after reset, replacing any file-based initialisation.
- Sits between decode (read addresses) and writeback (write ports) in the fewcore datapath.

Parameters:
- XLEN, 32, register width in bits.
- AMOUNT, 16, number of registers; must be ≤ 2**ADDRESSLEN.
- ADDRESSLEN, 4, register address width.
- NREAD, 2, number of read ports (1..8).
- ZERO_REG, 1, when 1, register 0 reads as 0 and writes to it are dropped.
- BYPASS, 1, when 1, same-cycle write data is forwarded to reads of the same address.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous reset, active-low.
- rs  in  NREAD*ADDRESSLEN  read addresses; port i occupies bits [i*ADDRESSLEN +: ADDRESSLEN].
- r  out  NREAD*XLEN  registered read data; port i occupies bits [i*XLEN +: XLEN].
- wEn0  in  1  write enable, port 0.
- rd0  in  ADDRESSLEN  write address, port 0.
- data0  in  XLEN  write data, port 0.
- wEn1  in  1  write enable, port 1; has priority over port 0.
- rd1  in  ADDRESSLEN  write address, port 1.
- data1  in  XLEN  write data, port 1.
- busy  out  1  high while the clear engine runs; core must stall.
- wconflict  out  1  registered 1-cycle pulse: both write ports hit the same effective address.

Behaviour:
Reset and clear:
- reset is sampled low at a posedge. Result: state <= CLEAR, clr_ptr <= 0, busy <= 1, all r <= 0, wconflict <= 0.
- CLEAR state: each cycle registers[clr_ptr] <= 0 and clr_ptr increments.
- When clr_ptr == AMOUNT-1, that last write occurs and the next state is RUN, with busy <= 0 on the same edge.
- Clear therefore takes exactly AMOUNT cycles after reset goes high.
- During CLEAR: wEn0/wEn1 are ignored, r holds 0, wconflict stays 0.
- reset asserted mid-CLEAR restarts the clear from address 0.
- Registers hold no defined value before the clear completes.

Write (RUN state only):
- Effective write of port k requires wEnk == 1, rdk < AMOUNT, and !(ZERO_REG && rdk == 0).
- Both effective on the same rd: port 1 data is stored, and wconflict pulses high the next cycle.
- Different rd: both are stored on the same edge.
- Out-of-range rd is silently dropped.

Read (RUN state only):
- Latency is 1 cycle: r[i] is updated at the posedge following rs[i] being presented.
- Value selection, in priority order:
  1. ZERO_REG && rs[i] == 0 → 0.
  2. rs[i] ≥ AMOUNT → 0.
  3. BYPASS && effective wEn1 && rd1 == rs[i] → data1.
  4. BYPASS && effective wEn0 && rd0 == rs[i] → data0.
  5. Otherwise → registers[rs[i]], the pre-edge contents.
- BYPASS = 0: a same-cycle write is not visible; the old value is returned, and the new value appears on a read issued one cycle later.
- All NREAD ports are independent; any ports may read the same address.

Storage and widths:
- All arithmetic is unsigned.
- clr_ptr is ADDRESSLEN bits wide.
- Storage is a flip-flop array; no file I/O and no simulation-only constructs.

Test Plan:
- Clear and busy timing: AMOUNT=16; hold reset low 2 cycles, then release → busy high exactly 16 cycles; every subsequent read returns 0; writes attempted while busy are not stored.
- Basic write/read: write 0xDEADBEEF to r5 via port 0; read r5 on all ports the next cycle → 0xDEADBEEF one cycle after rs is presented.
- Bypass: BYPASS=1; write 0x12345678 to r7 and read r7 in the same cycle → r = 0x12345678 next cycle. With BYPASS=0 the same stimulus returns the old value.
- Write conflict: wEn0/wEn1 both target r3 with 0x1111/0x2222 → r3 reads 0x2222; wconflict pulses for exactly 1 cycle. Repeat targeting r0 with ZERO_REG=1 → no pulse, and r0 reads 0.
- Zero register and range: ZERO_REG=1; write 0xFFFFFFFF to r0 → r0 reads 0. With AMOUNT=12, write to address 13 → dropped, and a read of address 13 returns 0.
- Reset mid-clear: release reset, reassert low at clear cycle 6, then release → busy stays high 16 more cycles; all registers read 0 afterwards.
